// File: rtl/cp0_if.sv
// Bus between the M stage of the pipeline and the CP0 exception controller.
// The master is the pipeline side and the slave is the CP0 controller.
interface cp0_if;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic        eret;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  modport master (
    output we, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, eret, hw_int,
    input  cp0_rdata, req, epc_out, handler_pc
  );

  modport slave (
    input  we, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, eret, hw_int,
    output cp0_rdata, req, epc_out, handler_pc
  );
endinterface

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 exception controller for the M stage of a 5-stage MIPS pipeline.
// Holds SR/Cause/EPC/PRId, raises req to redirect fetch to the handler, and
// services mfc0 reads and mtc0 writes. While EXL is set all new exceptions and
// interrupts are masked.
module cp0_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'h0000_0000,
  parameter logic [4:0]  EXC_INT      = 5'd0
) (
  input logic  clk,
  input logic  reset,
  cp0_if.slave bus
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  // Cause fields
  logic        bd_r;
  logic [5:0]  ip_r;
  logic [4:0]  exc_code_r;
  // EPC
  logic [31:0] epc_r;

  logic        int_req_s;
  logic        exc_req_s;
  logic        req_s;
  logic        sr_wr_s;
  logic        epc_wr_s;
  logic        exl_after_wr_s;
  logic [31:0] rdata_s;

  // Request decode: interrupts and exceptions, both masked by EXL and by reset.
  always_comb begin
    int_req_s = ie_r & ~exl_r & (|(bus.hw_int & im_r));
    exc_req_s = ~exl_r & (bus.exc_code_in != 5'd0);
    if (reset) begin
      req_s = 1'b0;
    end else begin
      req_s = int_req_s | exc_req_s;
    end
  end

  // mtc0 decode; a taking instruction must not commit its write.
  always_comb begin
    sr_wr_s  = bus.we & ~req_s & (bus.cp0_addr == REG_SR);
    epc_wr_s = bus.we & ~req_s & (bus.cp0_addr == REG_EPC);
    if (sr_wr_s) begin
      exl_after_wr_s = bus.cp0_wdata[1];
    end else begin
      exl_after_wr_s = exl_r;
    end
  end

  // CP0 register state: exception entry, eret, mtc0 and interrupt sampling.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_r       <= 6'd0;
      exl_r      <= 1'b0;
      ie_r       <= 1'b0;
      bd_r       <= 1'b0;
      ip_r       <= 6'd0;
      exc_code_r <= 5'd0;
      epc_r      <= 32'd0;
    end else begin
      ip_r <= bus.hw_int;
      if (req_s) begin
        // Exception entry wins over eret and mtc0 in the same cycle.
        exl_r <= 1'b1;
        bd_r  <= bus.bd_in;
        if (int_req_s) begin
          exc_code_r <= EXC_INT;
        end else begin
          exc_code_r <= bus.exc_code_in;
        end
        if (bus.bd_in) begin
          epc_r <= bus.vpc - 32'd4;
        end else begin
          epc_r <= bus.vpc;
        end
      end else begin
        if (sr_wr_s) begin
          im_r <= bus.cp0_wdata[15:10];
          ie_r <= bus.cp0_wdata[0];
        end
        // The mtc0 value lands first; an eret in the same cycle then clears EXL.
        if (bus.eret) begin
          exl_r <= 1'b0;
        end else begin
          exl_r <= exl_after_wr_s;
        end
        if (epc_wr_s) begin
          epc_r <= bus.cp0_wdata;
        end
      end
    end
  end

  // mfc0 read mux, live pre-edge values; unimplemented numbers read zero.
  always_comb begin
    case (bus.cp0_addr)
      REG_SR:    rdata_s = {16'd0, im_r, 8'd0, exl_r, ie_r};
      REG_CAUSE: rdata_s = {bd_r, 15'd0, ip_r, 3'd0, exc_code_r, 2'd0};
      REG_EPC:   rdata_s = epc_r;
      REG_PRID:  rdata_s = PRID_VALUE;
      default:   rdata_s = 32'd0;
    endcase
  end

  assign bus.req        = req_s;
  assign bus.cp0_rdata  = rdata_s;
  assign bus.epc_out    = epc_r;
  assign bus.handler_pc = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios followed by random
// traffic, all compared against a register-word level reference model.
module tb_cp0_ctrl;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID    = 32'h0000_0000;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  // Reference model: whole architectural register words.
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  cp0_if bus ();

  cp0_ctrl #(
    .HANDLER_ADDR(HANDLER),
    .PRID_VALUE  (PRID),
    .EXC_INT     (5'd0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    assert (got === exp) else begin
      bad = bad + 1;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // One clock of stimulus: drive at negedge, check outputs, advance model, wait edge.
  task automatic step(input logic rst, input logic w, input logic [4:0] a,
                      input logic [31:0] wd, input logic [31:0] pc, input logic bd,
                      input logic [4:0] exc, input logic er, input logic [5:0] hw,
                      input logic chk_rd, input logic [31:0] exp_rd);
    logic exl;
    logic ireq;
    logic ereq;
    logic take;
    @(negedge clk);
    reset           = rst;
    bus.we          = w;
    bus.cp0_addr    = a;
    bus.cp0_wdata   = wd;
    bus.vpc         = pc;
    bus.bd_in       = bd;
    bus.exc_code_in = exc;
    bus.eret        = er;
    bus.hw_int      = hw;
    #1;
    exl  = m_sr[1];
    ireq = m_sr[0] && !exl && ((hw & m_sr[15:10]) != 6'd0);
    ereq = !exl && (exc != 5'd0);
    take = !rst && (ireq || ereq);
    chk("req", {31'd0, bus.req}, {31'd0, take});
    chk("rdata", bus.cp0_rdata, model_read(a));
    chk("epc_out", bus.epc_out, m_epc);
    if (chk_rd) begin
      chk("rdata_dir", bus.cp0_rdata, exp_rd);
    end
    // Next architectural state.
    if (rst) begin
      m_sr    = 32'd0;
      m_cause = 32'd0;
      m_epc   = 32'd0;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
      if (take) begin
        m_sr    = m_sr | 32'h0000_0002;
        m_cause = (m_cause & ~32'h8000_007C) | (bd ? 32'h8000_0000 : 32'd0) |
                  (ireq ? 32'd0 : (32'(exc) << 2));
        m_epc   = bd ? pc - 32'd4 : pc;
      end else begin
        if (w && a == 5'd12) m_sr = wd & 32'h0000_FC03;
        if (w && a == 5'd14) m_epc = wd;
        if (er) m_sr = m_sr & ~32'h0000_0002;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    m_sr    = 32'd0;
    m_cause = 32'd0;
    m_epc   = 32'd0;
    reset   = 1'b1;
    bus.we = 1'b0; bus.cp0_addr = 5'd0; bus.cp0_wdata = 32'd0; bus.vpc = 32'd0;
    bus.bd_in = 1'b0; bus.exc_code_in = 5'd0; bus.eret = 1'b0; bus.hw_int = 6'd0;

    // 1. reset masks req; registers read zero afterwards
    step(1'b1, 1'b0, 5'd12, 32'd0, 32'h100, 1'b0, 5'd4, 1'b0, 6'h3F, 1'b0, 32'd0);
    step(1'b1, 1'b0, 5'd12, 32'd0, 32'h100, 1'b0, 5'd4, 1'b0, 6'h3F, 1'b0, 32'd0);
    step(1'b0, 1'b0, 5'd12, 32'd0, 32'h100, 1'b0, 5'd0, 1'b0, 6'h00, 1'b1, 32'd0);
    step(1'b0, 1'b0, 5'd13, 32'd0, 32'h100, 1'b0, 5'd0, 1'b0, 6'h00, 1'b1, 32'd0);
    step(1'b0, 1'b0, 5'd14, 32'd0, 32'h100, 1'b0, 5'd0, 1'b0, 6'h00, 1'b1, 32'd0);
    chk("handler_pc", bus.handler_pc, HANDLER);

    // 2. synchronous exception, then masked by EXL
    step(1'b0, 1'b0, 5'd0,  32'd0, 32'h3010, 1'b0, 5'd10, 1'b0, 6'h00, 1'b0, 32'd0);
    step(1'b0, 1'b0, 5'd14, 32'd0, 32'h3014, 1'b0, 5'd4,  1'b0, 6'h00, 1'b1, 32'h0000_3010);
    step(1'b0, 1'b0, 5'd13, 32'd0, 32'h3014, 1'b0, 5'd0,  1'b0, 6'h00, 1'b1, 32'h0000_0028);
    step(1'b0, 1'b0, 5'd12, 32'd0, 32'h3014, 1'b0, 5'd0,  1'b1, 6'h00, 1'b1, 32'h0000_0002);

    // 3. enabled interrupt in a delay slot
    step(1'b0, 1'b1, 5'd12, 32'h0000_0401, 32'h3020, 1'b0, 5'd0, 1'b0, 6'h00, 1'b0, 32'd0);
    step(1'b0, 1'b0, 5'd0,  32'd0, 32'h3024, 1'b1, 5'd0, 1'b0, 6'h01, 1'b0, 32'd0);
    step(1'b0, 1'b0, 5'd14, 32'd0, 32'h3028, 1'b0, 5'd0, 1'b0, 6'h00, 1'b1, 32'h0000_3020);
    step(1'b0, 1'b0, 5'd13, 32'd0, 32'h3028, 1'b0, 5'd0, 1'b1, 6'h00, 1'b1, 32'h8000_0000);

    // 4. interrupt beats exception; coincident eret ignored
    step(1'b0, 1'b0, 5'd0,  32'd0, 32'h3030, 1'b0, 5'd12, 1'b1, 6'h01, 1'b0, 32'd0);
    step(1'b0, 1'b0, 5'd13, 32'd0, 32'h3034, 1'b0, 5'd0,  1'b0, 6'h00, 1'b1, 32'h0000_0400);
    step(1'b0, 1'b0, 5'd12, 32'd0, 32'h3034, 1'b0, 5'd0,  1'b0, 6'h00, 1'b1, 32'h0000_0403);

    // 5. eret returns through EPC; mtc0 EPC readback
    step(1'b0, 1'b1, 5'd14, 32'h0000_3040, 32'h3038, 1'b0, 5'd0, 1'b0, 6'h00, 1'b0, 32'd0);
    step(1'b0, 1'b0, 5'd14, 32'd0, 32'h303C, 1'b0, 5'd0, 1'b1, 6'h00, 1'b1, 32'h0000_3040);
    chk("epc_out_eret", bus.epc_out, 32'h0000_3040);
    step(1'b0, 1'b0, 5'd12, 32'd0, 32'h3040, 1'b0, 5'd0, 1'b0, 6'h00, 1'b1, 32'h0000_0401);
    step(1'b0, 1'b1, 5'd14, 32'h0000_5000, 32'h3044, 1'b0, 5'd0, 1'b0, 6'h00, 1'b0, 32'd0);
    step(1'b0, 1'b0, 5'd14, 32'd0, 32'h3048, 1'b0, 5'd0, 1'b0, 6'h00, 1'b1, 32'h0000_5000);

    // 6. Cause not writable; mtc0 dropped on req
    step(1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF, 32'h304C, 1'b0, 5'd0, 1'b0, 6'h00, 1'b0, 32'd0);
    step(1'b0, 1'b0, 5'd13, 32'd0, 32'h3050, 1'b0, 5'd0, 1'b0, 6'h00, 1'b1, 32'h0000_0000);
    step(1'b0, 1'b1, 5'd12, 32'h0000_0000, 32'h3054, 1'b0, 5'd8, 1'b0, 6'h00, 1'b0, 32'd0);
    step(1'b0, 1'b0, 5'd12, 32'd0, 32'h3058, 1'b0, 5'd0, 1'b0, 6'h00, 1'b1, 32'h0000_0403);
    step(1'b0, 1'b1, 5'd12, 32'h0000_FC00, 32'h305C, 1'b0, 5'd0, 1'b1, 6'h00, 1'b1, 32'h0000_0403);
    step(1'b0, 1'b0, 5'd12, 32'd0, 32'h3060, 1'b0, 5'd0, 1'b0, 6'h00, 1'b1, 32'h0000_FC00);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  a;
      logic [31:0] wd;
      a  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) wd[0] = 1'b1;
      step(($urandom_range(0, 40) == 0),
           ($urandom_range(0, 2) == 0), a, wd,
           {$urandom, 2'b00} >> 0,
           1'($urandom),
           ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0,
           1'b0, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
